// File: rtl/pwr_ctrl_pkg.sv
// Shared types and register layout for the PD0 power controller register block.
// Also holds the sequencer's per-step delay rule.
package pwr_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_ON      = 4'd0,
    ST_ISO_ON  = 4'd1,
    ST_CLK_OFF = 4'd2,
    ST_RST_ON  = 4'd3,
    ST_PWR_OFF = 4'd4,
    ST_OFF     = 4'd5,
    ST_PWR_ON  = 4'd6,
    ST_RST_OFF = 4'd7,
    ST_CLK_ON  = 4'd8,
    ST_ISO_OFF = 4'd9
  } pd_state_e;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_DELAY  = 8'h08;
  localparam logic [7:0] ADDR_IRQ    = 8'h0C;

  localparam int CTRL_PD_REQ_BIT = 0;
  localparam int IRQ_DONE_BIT    = 0;
  localparam int STAT_BUSY_BIT   = 4;
  localparam int STAT_ACK_BIT    = 5;

  // A programmed delay of zero still dwells one cycle per step.
  function automatic logic [7:0] step_load(input logic [7:0] dly);
    return (dly == 8'd0) ? 8'd1 : dly;
  endfunction

endpackage

// File: rtl/pwr_ctrl_seq.sv
// Power-down/up sequencer: ordered iso/clock/reset/power steps with a programmable dwell.
// Domain outputs are registered and change only on entry to a step state.
module pwr_ctrl_seq
  import pwr_ctrl_pkg::*;
(
  input  logic       i_clk_apb,
  input  logic       i_rst_apb,
  input  logic       pd_req,
  input  logic [7:0] delay,
  input  logic       pwr_ack,
  output pd_state_e  state,
  output logic       done,
  output logic       iso_en,
  output logic       clk_en,
  output logic       pd_rst,
  output logic       pwr_en
);

  pd_state_e  state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       iso_reg, iso_next;
  logic       clk_reg, clk_next;
  logic       rst_reg, rst_next;
  logic       pwr_reg, pwr_next;
  logic       expired;
  logic [7:0] load;

  assign expired = (cnt_reg <= 8'd1);
  assign load    = step_load(delay);

  always_ff @(posedge i_clk_apb) begin
    if (i_rst_apb) begin
      state_reg <= ST_ON;
      cnt_reg   <= 8'd1;
      iso_reg   <= 1'b0;
      clk_reg   <= 1'b1;
      rst_reg   <= 1'b0;
      pwr_reg   <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      iso_reg   <= iso_next;
      clk_reg   <= clk_next;
      rst_reg   <= rst_next;
      pwr_reg   <= pwr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = expired ? cnt_reg : cnt_reg - 8'd1;
    iso_next   = iso_reg;
    clk_next   = clk_reg;
    rst_next   = rst_reg;
    pwr_next   = pwr_reg;
    done       = 1'b0;
    case (state_reg)
      ST_ON:      if (pd_req) begin
                    state_next = ST_ISO_ON;  cnt_next = load; iso_next = 1'b1;
                  end
      ST_ISO_ON:  if (expired) begin
                    state_next = ST_CLK_OFF; cnt_next = load; clk_next = 1'b0;
                  end
      ST_CLK_OFF: if (expired) begin
                    state_next = ST_RST_ON;  cnt_next = load; rst_next = 1'b1;
                  end
      ST_RST_ON:  if (expired) begin
                    state_next = ST_PWR_OFF; cnt_next = load; pwr_next = 1'b0;
                  end
      // The switch must confirm power is gone before the domain counts as off.
      ST_PWR_OFF: if (expired && !pwr_ack) begin
                    state_next = ST_OFF; done = 1'b1;
                  end
      ST_OFF:     if (!pd_req) begin
                    state_next = ST_PWR_ON;  cnt_next = load; pwr_next = 1'b1;
                  end
      ST_PWR_ON:  if (expired && pwr_ack) begin
                    state_next = ST_RST_OFF; cnt_next = load; rst_next = 1'b0;
                  end
      ST_RST_OFF: if (expired) begin
                    state_next = ST_CLK_ON;  cnt_next = load; clk_next = 1'b1;
                  end
      ST_CLK_ON:  if (expired) begin
                    state_next = ST_ISO_OFF; cnt_next = load; iso_next = 1'b0;
                  end
      ST_ISO_OFF: if (expired) begin
                    state_next = ST_ON; done = 1'b1;
                  end
      default: begin
        state_next = ST_ON;
        iso_next   = 1'b0;
        clk_next   = 1'b1;
        rst_next   = 1'b0;
        pwr_next   = 1'b1;
      end
    endcase
  end

  assign state  = state_reg;
  assign iso_en = iso_reg;
  assign clk_en = clk_reg;
  assign pd_rst = rst_reg;
  assign pwr_en = pwr_reg;

endmodule

// File: rtl/pwr_ctrl_regs_seq.sv
// Register target behind apb_slave: decode, CTRL/DELAY/IRQ registers, one-shot ready,
// registered read return, and the power sequencer instance.
module pwr_ctrl_regs_seq
  import pwr_ctrl_pkg::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [7:0] DLY_RST    = 8'd4
) (
  input  logic                  i_clk_apb,
  input  logic                  i_rst_apb,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_rd0_wr1,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_pd_iso_en,
  output logic                  o_pd_clk_en,
  output logic                  o_pd_rst,
  output logic                  o_pd_pwr_en,
  input  logic                  i_pd_pwr_ack,
  output logic                  o_irq
);

  logic                  accept, wr_acc, rd_acc;
  logic [7:0]            offset;
  logic                  ready_reg, rd_valid_reg;
  logic [DATA_WIDTH-1:0] rd_data_reg, rd_mux;
  logic                  ctrl_reg, irq_reg;
  logic [7:0]            delay_reg;
  pd_state_e             seq_state;
  logic                  seq_done, busy;
  logic                  unused_bits;

  assign unused_bits = ^{i_addr, i_wr_data};
  assign offset      = i_addr[7:0];
  assign accept      = i_valid & ready_reg;
  assign wr_acc      = accept & i_rd0_wr1;
  assign rd_acc      = accept & ~i_rd0_wr1;
  assign busy        = (seq_state != ST_ON) && (seq_state != ST_OFF);

  always_comb begin
    rd_mux = '0;
    case (offset)
      ADDR_CTRL:   rd_mux[CTRL_PD_REQ_BIT] = ctrl_reg;
      ADDR_STATUS: begin
        rd_mux[3:0]           = seq_state;
        rd_mux[STAT_BUSY_BIT] = busy;
        rd_mux[STAT_ACK_BIT]  = i_pd_pwr_ack;
      end
      ADDR_DELAY:  rd_mux[7:0] = delay_reg;
      ADDR_IRQ:    rd_mux[IRQ_DONE_BIT] = irq_reg;
      default:     rd_mux = '0;
    endcase
  end

  // Ready drops for the single cycle after an accept so a held valid is not taken twice.
  always_ff @(posedge i_clk_apb) begin
    if (i_rst_apb) begin
      ready_reg    <= 1'b1;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
      ctrl_reg     <= 1'b0;
      delay_reg    <= DLY_RST;
      irq_reg      <= 1'b0;
    end else begin
      ready_reg    <= ~accept;
      rd_valid_reg <= rd_acc;
      rd_data_reg  <= rd_acc ? rd_mux : '0;
      if (wr_acc && offset == ADDR_CTRL)  ctrl_reg  <= i_wr_data[CTRL_PD_REQ_BIT];
      if (wr_acc && offset == ADDR_DELAY) delay_reg <= i_wr_data[7:0];
      if (seq_done)
        irq_reg <= 1'b1;
      else if (wr_acc && offset == ADDR_IRQ && i_wr_data[IRQ_DONE_BIT])
        irq_reg <= 1'b0;
    end
  end

  pwr_ctrl_seq u_seq (
    .i_clk_apb (i_clk_apb),
    .i_rst_apb (i_rst_apb),
    .pd_req    (ctrl_reg),
    .delay     (delay_reg),
    .pwr_ack   (i_pd_pwr_ack),
    .state     (seq_state),
    .done      (seq_done),
    .iso_en    (o_pd_iso_en),
    .clk_en    (o_pd_clk_en),
    .pd_rst    (o_pd_rst),
    .pwr_en    (o_pd_pwr_en)
  );

  assign o_ready    = ready_reg;
  assign o_rd_valid = rd_valid_reg;
  assign o_rd_data  = rd_data_reg;
  assign o_irq      = irq_reg;

endmodule

// File: tb/tb_pwr_ctrl_regs_seq.sv
// Bench for pwr_ctrl_regs_seq: directed scenarios plus random bus traffic, all outputs
// compared every cycle against a behavioural model of the register block and sequence.
module tb_pwr_ctrl_regs_seq;

  logic        i_clk_apb = 1'b0;
  logic        i_rst_apb = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_rd0_wr1 = 1'b0;
  logic        i_pd_pwr_ack = 1'b1;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wr_data = '0;
  logic        o_ready, o_rd_valid, o_irq;
  logic        o_pd_iso_en, o_pd_clk_en, o_pd_rst, o_pd_pwr_en;
  logic [31:0] o_rd_data;

  always #5 i_clk_apb = ~i_clk_apb;

  pwr_ctrl_regs_seq #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DLY_RST(8'd4)) dut (
    .i_clk_apb    (i_clk_apb),
    .i_rst_apb    (i_rst_apb),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_addr       (i_addr),
    .i_rd0_wr1    (i_rd0_wr1),
    .i_wr_data    (i_wr_data),
    .o_rd_valid   (o_rd_valid),
    .o_rd_data    (o_rd_data),
    .o_pd_iso_en  (o_pd_iso_en),
    .o_pd_clk_en  (o_pd_clk_en),
    .o_pd_rst     (o_pd_rst),
    .o_pd_pwr_en  (o_pd_pwr_en),
    .i_pd_pwr_ack (i_pd_pwr_ack),
    .o_irq        (o_irq)
  );

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;

  // Switch model: ack follows pwr_en three cycles later unless forced low.
  logic [2:0] pwr_hist = 3'b111;
  bit         ack_hold = 1'b0;
  int         chg_cyc[4];
  logic [3:0] pd_prev = 4'b0101;

  // Reference model: state index 0..9 along the ring, age = cycles spent in this step.
  int          m_state = 0;
  int          m_age = 0;
  int          m_need = 1;
  logic        m_ctrl = 1'b0;
  logic [7:0]  m_delay = 8'd4;
  logic        m_irq = 1'b0;
  logic        m_ready = 1'b1;
  logic        m_rd_valid = 1'b0;
  logic [31:0] m_rd_data = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // {iso_en, clk_en, pd_rst, pwr_en}: down path turns things off progressively, up path back on.
  function automatic logic [3:0] exp_pd(input int s);
    if (s <= 5) return {s >= 1, s < 2, s >= 3, s < 4};
    return {s < 9, s >= 8, s < 7, 1'b1};
  endfunction

  task automatic model_step();
    bit         acc, wr, done, w1c;
    logic [7:0] off;
    if (i_rst_apb) begin
      m_state = 0; m_age = 0; m_need = 1; m_ctrl = 1'b0; m_delay = 8'd4;
      m_irq = 1'b0; m_ready = 1'b1; m_rd_valid = 1'b0; m_rd_data = '0;
      return;
    end
    off = i_addr[7:0];
    acc = i_valid && m_ready;
    wr  = acc && i_rd0_wr1;
    m_rd_valid = acc && !i_rd0_wr1;
    m_rd_data  = '0;
    if (m_rd_valid) begin
      if (off == 8'h00)      m_rd_data = {31'd0, m_ctrl};
      else if (off == 8'h04) m_rd_data = (i_pd_pwr_ack ? 32'h20 : 32'h0)
                                       + ((m_state != 0 && m_state != 5) ? 32'h10 : 32'h0)
                                       + 32'(m_state);
      else if (off == 8'h08) m_rd_data = {24'd0, m_delay};
      else if (off == 8'h0C) m_rd_data = {31'd0, m_irq};
    end
    done = 1'b0;
    if (m_state == 0 || m_state == 5) begin
      if ((m_state == 0 && m_ctrl) || (m_state == 5 && !m_ctrl)) begin
        m_state++; m_age = 0; m_need = (m_delay == 0) ? 1 : int'(m_delay);
      end
    end else begin
      m_age++;
      if (m_age >= m_need && !(m_state == 4 && i_pd_pwr_ack) && !(m_state == 6 && !i_pd_pwr_ack)) begin
        m_state = (m_state + 1) % 10;
        m_age = 0;
        m_need = (m_delay == 0) ? 1 : int'(m_delay);
        done = (m_state == 0 || m_state == 5);
      end
    end
    w1c = wr && off == 8'h0C && i_wr_data[0];
    if (wr && off == 8'h00) m_ctrl = i_wr_data[0];
    if (wr && off == 8'h08) m_delay = i_wr_data[7:0];
    if (done) m_irq = 1'b1;
    else if (w1c) m_irq = 1'b0;
    m_ready = !acc;
  endtask

  task automatic tick();
    logic [3:0] pd_now;
    model_step();
    @(posedge i_clk_apb);
    @(negedge i_clk_apb);
    cyc++;
    pd_now = {o_pd_iso_en, o_pd_clk_en, o_pd_rst, o_pd_pwr_en};
    check_val("pd_outs", pd_now, exp_pd(m_state));
    check_val("ready", o_ready, m_ready);
    check_val("rd_valid", o_rd_valid, m_rd_valid);
    check_val("rd_data", o_rd_data, m_rd_data);
    check_val("irq", o_irq, m_irq);
    for (int i = 0; i < 4; i++)
      if (pd_now[i] !== pd_prev[i]) chg_cyc[i] = cyc;
    pd_prev = pd_now;
    pwr_hist = {pwr_hist[1:0], o_pd_pwr_en};
    i_pd_pwr_ack = ack_hold ? 1'b0 : pwr_hist[2];
  endtask

  task automatic bus_xfer(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                          output logic [31:0] rdata);
    int          guard;
    logic [31:0] hi;
    guard = 0;
    while (!o_ready && guard < 8) begin
      tick();
      guard++;
    end
    hi = $urandom();
    i_valid = 1'b1; i_rd0_wr1 = wr; i_addr = {hi[31:8], addr}; i_wr_data = data;
    tick();
    rdata = o_rd_data;
    i_valid = 1'b0; i_rd0_wr1 = 1'b0;
    $display("[TB] %s addr=0x%02h data=0x%08h", wr ? "WR" : "RD", addr, wr ? data : rdata);
    tick();
  endtask

  task automatic wait_state(input int s, input int budget, input string tag);
    int n;
    n = 0;
    while (m_state != s && n < budget) begin
      tick();
      n++;
    end
    check_val(tag, {o_pd_iso_en, o_pd_clk_en, o_pd_rst, o_pd_pwr_en}, exp_pd(s));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, want done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, rnd;
    int          pulses, r;
    logic [7:0]  addr_tab[6];
    addr_tab = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h3C};

    tick(); tick();
    i_rst_apb = 1'b0;
    check_val("rst_pd_outs", {o_pd_iso_en, o_pd_clk_en, o_pd_rst, o_pd_pwr_en}, 4'b0101);
    check_val("rst_ready", o_ready, 1'b1);
    check_val("rst_irq", o_irq, 1'b0);

    bus_xfer(1'b0, 8'h04, '0, rd);
    check_val("status_reset", rd, 32'h20);
    bus_xfer(1'b0, 8'h08, '0, rd);
    check_val("delay_reset", rd, 32'h04);

    // Held valid: one accept, ready goes 1,0,1.
    i_valid = 1'b1; i_rd0_wr1 = 1'b1; i_addr = 32'h08; i_wr_data = 32'h02;
    check_val("ready_p0", o_ready, 1'b1);
    tick(); check_val("ready_p1", o_ready, 1'b0);
    tick(); check_val("ready_p2", o_ready, 1'b1);
    i_valid = 1'b0; i_rd0_wr1 = 1'b0;
    tick();
    bus_xfer(1'b0, 8'h08, '0, rd);
    check_val("delay_rb", rd, 32'h02);
    i_valid = 1'b1; i_addr = 32'h08;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (o_rd_valid) pulses++;
      if (k == 1) i_valid = 1'b0;
    end
    check_val("held_read_pulses", pulses, 1);

    // Power down with DELAY=2.
    bus_xfer(1'b1, 8'h00, 32'h1, rd);
    wait_state(5, 200, "reach_off");
    check_val("dn_iso_to_clk", chg_cyc[2] - chg_cyc[3], 2);
    check_val("dn_clk_to_rst", chg_cyc[1] - chg_cyc[2], 2);
    check_val("dn_rst_to_pwr", chg_cyc[0] - chg_cyc[1], 2);
    bus_xfer(1'b0, 8'h04, '0, rd);
    check_val("status_off", rd, 32'h05);
    check_val("irq_after_off", o_irq, 1'b1);

    bus_xfer(1'b1, 8'h0C, 32'h1, rd);
    check_val("irq_w1c", o_irq, 1'b0);

    // Power up with the switch refusing to acknowledge.
    ack_hold = 1'b1;
    bus_xfer(1'b1, 8'h00, 32'h0, rd);
    for (int k = 0; k < 20; k++) tick();
    bus_xfer(1'b0, 8'h04, '0, rd);
    check_val("status_pwr_on_wait", rd, 32'h16);
    ack_hold = 1'b0;
    wait_state(9, 200, "reach_iso_off");
    for (int k = 0; k < 20 && m_state == 9; k++) begin
      if (m_age + 1 >= m_need && o_ready) begin
        i_valid = 1'b1; i_rd0_wr1 = 1'b1; i_addr = 32'h0C; i_wr_data = 32'h1;
        tick();
        i_valid = 1'b0; i_rd0_wr1 = 1'b0;
        check_val("irq_set_wins", o_irq, 1'b1);
      end else begin
        tick();
      end
    end
    check_val("up_rst_to_clk", chg_cyc[2] - chg_cyc[1], 2);
    check_val("up_clk_to_iso", chg_cyc[3] - chg_cyc[2], 2);
    tick();

    // DELAY=0 gives single-cycle steps; reset lands mid CLK_OFF.
    bus_xfer(1'b1, 8'h08, 32'h0, rd);
    bus_xfer(1'b1, 8'h00, 32'h1, rd);
    wait_state(2, 20, "reach_clk_off");
    check_val("dly0_iso_to_clk", chg_cyc[2] - chg_cyc[3], 1);
    i_rst_apb = 1'b1;
    tick();
    i_rst_apb = 1'b0;
    check_val("midrst_pd_outs", {o_pd_iso_en, o_pd_clk_en, o_pd_rst, o_pd_pwr_en}, 4'b0101);
    check_val("midrst_irq", o_irq, 1'b0);
    check_val("midrst_ready", o_ready, 1'b1);
    bus_xfer(1'b0, 8'h08, '0, rd);
    check_val("midrst_delay", rd, 32'h04);
    bus_xfer(1'b0, 8'h00, '0, rd);
    check_val("midrst_ctrl", rd, 32'h0);

    // Random traffic against the model.
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        i_rst_apb = 1'b1;
        tick();
        i_rst_apb = 1'b0;
      end else if (r < 5) begin
        ack_hold = ~ack_hold;
        tick();
      end else if (r < 35) begin
        for (int j = 0; j < int'($urandom_range(1, 6)); j++) tick();
      end else begin
        rnd = $urandom();
        if (r < 60) rnd[7:0] = 8'($urandom_range(0, 3));
        bus_xfer(1'($urandom_range(0, 1)), addr_tab[$urandom_range(0, 5)], rnd, rd);
      end
    end
    ack_hold = 1'b0;
    for (int k = 0; k < 10; k++) tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
